// File: rtl/cp0_pkg.sv
// CP0 shared definitions: op codes, register numbers, field positions.
package cp0_pkg;

    localparam logic [2:0] CP0OP_MFC0    = 3'b001;
    localparam logic [2:0] CP0OP_MTC0    = 3'b010;
    localparam logic [2:0] CP0OP_ERET    = 3'b011;
    localparam logic [2:0] CP0OP_SYSCALL = 3'b100;

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    localparam int ST_IE  = 0;
    localparam int ST_EXL = 1;
    localparam int IM_LO  = 10;
    localparam int IM_HI  = 15;

    localparam logic [31:0] STATUS_MASK = 32'h0000_FC03;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_REDIRECT = 1'b1
    } state_t;

endpackage

// File: rtl/cp0_regfile.sv
// Status/Cause/EPC storage, field masking, read mux and interrupt-pending term.
module cp0_regfile
    import cp0_pkg::*;
#(
    parameter int NUM_IRQ = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               we,
    input  logic [4:0]         waddr,
    input  logic [31:0]        wdata,
    input  logic               exc_enter,
    input  logic [4:0]         exc_code,
    input  logic [31:0]        exc_pc,
    input  logic               exc_ret,
    input  logic [4:0]         rd_addr,
    output logic [31:0]        rdata,
    output logic [31:0]        epc,
    output logic               int_pend
);

    logic [31:0] status;
    logic [5:0]  ip;
    logic [4:0]  excode;
    logic [31:0] cause;

    assign cause = {16'b0, ip, 3'b0, excode, 2'b0};

    assign int_pend = status[ST_IE] & ~status[ST_EXL]
                    & |(status[IM_HI:IM_LO] & ip);

    // ip doubles as the single-flop irq synchronizer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            status <= '0;
            ip     <= '0;
            excode <= '0;
            epc    <= '0;
        end else begin
            ip <= 6'(irq);
            if (exc_enter) begin
                epc            <= exc_pc;
                excode         <= exc_code;
                status[ST_EXL] <= 1'b1;
            end else if (exc_ret) begin
                status[ST_EXL] <= 1'b0;
            end else if (we) begin
                case (waddr)
                    CP0_STATUS: status <= wdata & STATUS_MASK;
                    CP0_EPC:    epc    <= wdata;
                    default:    ;
                endcase
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (rd_addr)
            CP0_STATUS: rdata = status;
            CP0_CAUSE:  rdata = cause;
            CP0_EPC:    rdata = epc;
            default:    rdata = '0;
        endcase
    end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception controller: commit-stage priority decode and redirect FSM.
module cp0_exc_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0180,
    parameter int          NUM_IRQ    = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wb_valid,
    input  logic [2:0]         wb_cp0op,
    input  logic [4:0]         wb_rd,
    input  logic [31:0]        wb_wdata,
    input  logic [31:0]        wb_pc,
    input  logic [4:0]         rd_addr,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               redirect_ready,
    output logic [31:0]        rdata,
    output logic               flush,
    output logic               redirect_valid,
    output logic [31:0]        redirect_pc,
    output logic               exc_busy
);

    state_t      state;
    logic [31:0] epc;
    logic        int_pend;
    logic        commit;
    logic        take_int;
    logic        take_sys;
    logic        take_eret;
    logic        do_mtc0;

    assign commit = wb_valid & (state == S_IDLE);

    // interrupt outranks every op, including a same-cycle mtc0
    always_comb begin
        take_int  = 1'b0;
        take_sys  = 1'b0;
        take_eret = 1'b0;
        do_mtc0   = 1'b0;
        if (commit) begin
            unique case (1'b1)
                int_pend:                                take_int  = 1'b1;
                !int_pend && wb_cp0op == CP0OP_SYSCALL: take_sys  = 1'b1;
                !int_pend && wb_cp0op == CP0OP_ERET:    take_eret = 1'b1;
                !int_pend && wb_cp0op == CP0OP_MTC0:    do_mtc0   = 1'b1;
                default: ;
            endcase
        end
    end

    cp0_regfile #(
        .NUM_IRQ(NUM_IRQ)
    ) u_regs (
        .clk      (clk),
        .rst_n    (rst_n),
        .irq      (irq),
        .we       (do_mtc0),
        .waddr    (wb_rd),
        .wdata    (wb_wdata),
        .exc_enter(take_int | take_sys),
        .exc_code (take_int ? EXC_INT : EXC_SYS),
        .exc_pc   (wb_pc),
        .exc_ret  (take_eret),
        .rd_addr  (rd_addr),
        .rdata    (rdata),
        .epc      (epc),
        .int_pend (int_pend)
    );

    assign flush = redirect_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            exc_busy       <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (take_int | take_sys | take_eret) begin
                        state          <= S_REDIRECT;
                        redirect_valid <= 1'b1;
                        exc_busy       <= 1'b1;
                        redirect_pc    <= take_eret ? epc : EXC_VECTOR;
                    end
                end
                S_REDIRECT: begin
                    if (redirect_ready) begin
                        state          <= S_IDLE;
                        redirect_valid <= 1'b0;
                        exc_busy       <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Bench for cp0_exc_ctrl: vector table, directed corner sequences, random vs model.
module tb_cp0_exc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_valid;
    logic [2:0]  wb_cp0op;
    logic [4:0]  wb_rd;
    logic [31:0] wb_wdata;
    logic [31:0] wb_pc;
    logic [4:0]  rd_addr;
    logic [5:0]  irq;
    logic        redirect_ready;
    logic [31:0] rdata;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        exc_busy;

    always #5 clk = ~clk;

    cp0_exc_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wb_valid      (wb_valid),
        .wb_cp0op      (wb_cp0op),
        .wb_rd         (wb_rd),
        .wb_wdata      (wb_wdata),
        .wb_pc         (wb_pc),
        .rd_addr       (rd_addr),
        .irq           (irq),
        .redirect_ready(redirect_ready),
        .rdata         (rdata),
        .flush         (flush),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .exc_busy      (exc_busy)
    );

    int errs   = 0;
    int checks = 0;

    typedef struct {
        logic        valid;
        logic [2:0]  op;
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic [31:0] pc;
        logic [5:0]  irq;
        logic        ready;
        logic [4:0]  raddr;
        logic [31:0] pre;
        logic [31:0] post;
        logic        rv;
        logic [31:0] rpc;
    } vec_t;

    vec_t tbl[13];

    // reference state, kept as architectural words
    logic [31:0] m_status, m_cause, m_epc, m_rpc;
    logic        m_busy;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op,
                         input logic [4:0] rd, input logic [31:0] wd,
                         input logic [31:0] pc, input logic [5:0] iq,
                         input logic rdy, input logic [4:0] ra);
        wb_valid       = v;
        wb_cp0op       = op;
        wb_rd          = rd;
        wb_wdata       = wd;
        wb_pc          = pc;
        irq            = iq;
        redirect_ready = rdy;
        rd_addr        = ra;
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd12:   return m_status;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_edge(input logic rst, input logic v,
                              input logic [2:0] op, input logic [4:0] rd,
                              input logic [31:0] wd, input logic [31:0] pc,
                              input logic [5:0] iq, input logic rdy);
        logic        pend;
        logic [31:0] old_epc;
        if (!rst) begin
            m_status = 0; m_cause = 0; m_epc = 0;
            m_rpc = 0; m_busy = 0;
            return;
        end
        pend = m_status[0] && !m_status[1]
             && ((m_status[15:10] & m_cause[15:10]) != 6'd0);
        old_epc = m_epc;
        if (!m_busy) begin
            if (v) begin
                if (pend || op == 3'd4) begin
                    m_epc        = pc;
                    m_cause[6:2] = pend ? 5'd0 : 5'd8;
                    m_status[1]  = 1'b1;
                    m_rpc        = 32'h180;
                    m_busy       = 1'b1;
                end else if (op == 3'd3) begin
                    m_status[1] = 1'b0;
                    m_rpc       = old_epc;
                    m_busy      = 1'b1;
                end else if (op == 3'd2) begin
                    if (rd == 5'd12) m_status = wd & 32'h0000_FC03;
                    else if (rd == 5'd14) m_epc = wd;
                end
            end
        end else if (rdy) begin
            m_busy = 1'b0;
        end
        m_cause[15:10] = iq;
    endtask

    initial begin
        //          v    op     rd     wdata         pc        irq  rdy  raddr  pre           post          rv   rpc
        tbl[0]  = '{0, 3'd0, 5'd0,  32'h0,        32'h0,    6'd0, 1, 5'd12, 32'h0,        32'h0,        0, 32'h0};
        tbl[1]  = '{0, 3'd0, 5'd0,  32'h0,        32'h0,    6'd0, 1, 5'd13, 32'h0,        32'h0,        0, 32'h0};
        tbl[2]  = '{0, 3'd0, 5'd0,  32'h0,        32'h0,    6'd0, 1, 5'd14, 32'h0,        32'h0,        0, 32'h0};
        tbl[3]  = '{1, 3'd2, 5'd12, 32'hFFFF_FFFF, 32'h0,   6'd0, 1, 5'd12, 32'h0,        32'h0000_FC03, 0, 32'h0};
        tbl[4]  = '{1, 3'd2, 5'd12, 32'h0,        32'h0,    6'd0, 1, 5'd12, 32'h0000_FC03, 32'h0,       0, 32'h0};
        tbl[5]  = '{1, 3'd4, 5'd0,  32'h0,        32'h40,   6'd0, 1, 5'd14, 32'h0,        32'h40,       1, 32'h180};
        tbl[6]  = '{0, 3'd0, 5'd0,  32'h0,        32'h0,    6'd0, 1, 5'd13, 32'h20,       32'h20,       0, 32'h180};
        tbl[7]  = '{0, 3'd0, 5'd0,  32'h0,        32'h0,    6'd0, 1, 5'd12, 32'h2,        32'h2,        0, 32'h180};
        tbl[8]  = '{1, 3'd2, 5'd12, 32'h401,      32'h0,    6'd1, 1, 5'd12, 32'h2,        32'h401,      0, 32'h180};
        tbl[9]  = '{1, 3'd2, 5'd14, 32'hDEAD_BEEF, 32'h100, 6'd1, 1, 5'd14, 32'h40,       32'h100,      1, 32'h180};
        tbl[10] = '{0, 3'd0, 5'd0,  32'h0,        32'h0,    6'd0, 1, 5'd13, 32'h400,      32'h0,        0, 32'h180};
        tbl[11] = '{0, 3'd0, 5'd0,  32'h0,        32'h0,    6'd0, 1, 5'd12, 32'h403,      32'h403,      0, 32'h180};
        tbl[12] = '{1, 3'd2, 5'd14, 32'h200,      32'h0,    6'd0, 1, 5'd14, 32'h100,      32'h200,      0, 32'h180};

        rst_n = 1'b0;
        drive(0, 3'd0, 5'd0, 32'h0, 32'h0, 6'd0, 1'b0, 5'd12);
        tick;
        tick;
        chk("rst_rv", 32'(redirect_valid), 32'h0);
        chk("rst_busy", 32'(exc_busy), 32'h0);
        chk("rst_rpc", redirect_pc, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].valid, tbl[i].op, tbl[i].rd, tbl[i].wdata,
                  tbl[i].pc, tbl[i].irq, tbl[i].ready, tbl[i].raddr);
            #1;
            chk($sformatf("v%0d_pre", i), rdata, tbl[i].pre);
            tick;
            chk($sformatf("v%0d_rdata", i), rdata, tbl[i].post);
            chk($sformatf("v%0d_rv", i), 32'(redirect_valid), 32'(tbl[i].rv));
            chk($sformatf("v%0d_flush", i), 32'(flush), 32'(tbl[i].rv));
            chk($sformatf("v%0d_busy", i), 32'(exc_busy), 32'(tbl[i].rv));
            chk($sformatf("v%0d_rpc", i), redirect_pc, tbl[i].rpc);
        end

        // eret under backpressure; syscalls in the window are ignored
        drive(1, 3'd3, 5'd0, 32'h0, 32'h0, 6'd0, 1'b0, 5'd14);
        tick;
        chk("eret_rv0", 32'(redirect_valid), 32'h1);
        chk("eret_rpc0", redirect_pc, 32'h200);
        for (int k = 1; k < 3; k++) begin
            drive(1, 3'd4, 5'd0, 32'h0, 32'h300, 6'd0, 1'b0, 5'd14);
            tick;
            chk($sformatf("eret_rv%0d", k), 32'(redirect_valid), 32'h1);
            chk($sformatf("eret_rpc%0d", k), redirect_pc, 32'h200);
            chk($sformatf("eret_epc%0d", k), rdata, 32'h200);
        end
        drive(0, 3'd0, 5'd0, 32'h0, 32'h0, 6'd0, 1'b1, 5'd12);
        tick;
        chk("eret_done_rv", 32'(redirect_valid), 32'h0);
        chk("eret_done_busy", 32'(exc_busy), 32'h0);
        chk("eret_status", rdata, 32'h401);

        // pending interrupt without a committing instruction: no event
        drive(0, 3'd4, 5'd0, 32'h0, 32'h0, 6'd1, 1'b1, 5'd14);
        tick;
        tick;
        chk("novalid_rv", 32'(redirect_valid), 32'h0);
        chk("novalid_epc", rdata, 32'h200);
        drive(1, 3'd0, 5'd0, 32'h0, 32'h500, 6'd1, 1'b1, 5'd14);
        tick;
        chk("irq_rv", 32'(redirect_valid), 32'h1);
        chk("irq_epc", rdata, 32'h500);
        chk("irq_rpc", redirect_pc, 32'h180);
        drive(0, 3'd0, 5'd0, 32'h0, 32'h0, 6'd0, 1'b1, 5'd14);
        tick;
        chk("irq_done_rv", 32'(redirect_valid), 32'h0);

        // reset while a redirect is pending
        drive(1, 3'd4, 5'd0, 32'h0, 32'h600, 6'd0, 1'b0, 5'd14);
        tick;
        chk("mid_rv", 32'(redirect_valid), 32'h1);
        rst_n = 1'b0;
        drive(0, 3'd0, 5'd0, 32'h0, 32'h0, 6'd0, 1'b0, 5'd14);
        tick;
        chk("mid_rst_rv", 32'(redirect_valid), 32'h0);
        chk("mid_rst_busy", 32'(exc_busy), 32'h0);
        chk("mid_rst_rpc", redirect_pc, 32'h0);
        chk("mid_rst_epc", rdata, 32'h0);
        rst_n = 1'b1;

        m_status = 0; m_cause = 0; m_epc = 0; m_rpc = 0; m_busy = 0;
        for (int n = 0; n < 400; n++) begin
            logic        r, v, rdy;
            logic [2:0]  op;
            logic [4:0]  rd, ra;
            logic [31:0] wd, pc;
            logic [5:0]  iq;
            r   = ($urandom_range(0, 60) != 0);
            v   = ($urandom_range(0, 3) != 0);
            op  = 3'($urandom_range(0, 7));
            rd  = 5'($urandom_range(0, 31));
            if (rd == 5'd13) rd = 5'd14;
            if ($urandom_range(0, 1) == 0) rd = 5'd12;
            wd  = $urandom;
            pc  = $urandom & 32'hFFFF_FFFC;
            iq  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : irq;
            rdy = ($urandom_range(0, 2) != 0);
            ra  = ($urandom_range(0, 3) == 0) ? 5'($urandom)
                                              : 5'($urandom_range(12, 14));
            rst_n = r;
            drive(v, op, rd, wd, pc, iq, rdy, ra);
            model_edge(r, v, op, rd, wd, pc, iq, rdy);
            tick;
            chk($sformatf("rnd%0d_rv", n), 32'(redirect_valid), 32'(m_busy));
            chk($sformatf("rnd%0d_flush", n), 32'(flush), 32'(m_busy));
            chk($sformatf("rnd%0d_busy", n), 32'(exc_busy), 32'(m_busy));
            chk($sformatf("rnd%0d_rpc", n), redirect_pc, m_rpc);
            chk($sformatf("rnd%0d_rdata", n), rdata, m_read(ra));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
- Owns CP0 Status (reg 12), Cause (reg 13) and EPC (reg 14) for the 5-stage MIPS pipeline, and sequences exception entry and ERET.
- Sits at write-back: commits mtc0, takes syscall and external interrupts, and drives the flush/redirect handshake to fetch.
- Supplies the CP0 read data that the mem/wr stages carry as cp0_dout for mfc0 forwarding.

Parameters:
- EXC_VECTOR, 32'h0000_0180, handler entry PC.
- NUM_IRQ, 6, external interrupt lines; maps to Status.IM / Cause.IP bits [15:10].

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- wb_valid  in  1  instruction committing this cycle.
- wb_cp0op  in  3  001 mfc0, 010 mtc0, 011 eret, 100 syscall, others none.
- wb_rd  in  5  CP0 register number for mtc0.
- wb_wdata  in  32  mtc0 write data.
- wb_pc  in  32  PC of the committing instruction.
- rd_addr  in  5  CP0 read address (mfc0 in ex/mem).
- irq  in  NUM_IRQ  level-sensitive external interrupts.
- redirect_ready  in  1  fetch accepts the redirect.
- rdata  out  32  CP0 read data, combinational from rd_addr.
- flush  out  1  kill IF..MEM; equals redirect_valid.
- redirect_valid  out  1  redirect request.
- redirect_pc  out  32  target PC.
- exc_busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - Status, Cause and EPC = 0. State = IDLE.
  - irq sync flop = 0.
  - redirect_valid, flush and exc_busy = 0. redirect_pc = 0.
- Register fields:
  - Status: [15:10] IM, [1] EXL, [0] IE. Other bits read 0 and are not writable.
  - Cause: [15:10] IP, read-only and loaded each cycle from the 1-flop synchronized irq. [6:2] ExcCode (Int=0, Sys=8). Other bits read 0.
  - EPC: full 32 bits, writable by mtc0.
- rdata:
  - Register value for rd_addr 12/13/14; 0 for any other address.
  - A read in the same cycle as a write returns the old value; the forwarding unit covers the hazard.
- int_pend = IE & ~EXL & |(IM & IP).
- States: IDLE, REDIRECT.
- IDLE, evaluated only when wb_valid=1, priority highest first:
  1. int_pend (any op): EPC<=wb_pc, ExcCode<=0, EXL<=1, redirect_pc<=EXC_VECTOR, go to REDIRECT. Any mtc0 in the same cycle is suppressed; the instruction re-executes after the handler.
  2. syscall: EPC<=wb_pc, ExcCode<=8, EXL<=1, redirect_pc<=EXC_VECTOR, go to REDIRECT.
  3. eret: EXL<=0, redirect_pc<=EPC (value before this edge), go to REDIRECT.
  4. mtc0: write the addressed writable fields at the edge; stay in IDLE. Unmapped address is ignored.
  5. Otherwise: no change.
- wb_valid=0 in IDLE: no event, even if int_pend is set.
- REDIRECT:
  - redirect_valid=1, flush=1, exc_busy=1.
  - redirect_pc is held stable until the handshake completes.
  - redirect_valid & redirect_ready at the edge: go to IDLE; outputs drop next cycle.
  - Without ready, hold indefinitely.
  - Any wb_valid or op in REDIRECT is ignored (the pipeline is flushing).
- Latency:
  - The event commits at edge N.
  - redirect_valid is high from cycle N+1.
  - Minimum return to IDLE at edge N+1 when ready=1.
- Reset mid-REDIRECT: next edge returns to IDLE with all outputs 0 and registers cleared.
- irq deasserting while in REDIRECT has no effect on the entered exception.

Decomposition:
- Shared package cp0_pkg holds:
  - CP0OP_MFC0/MTC0/ERET/SYSCALL codes (3-bit).
  - CP0 register numbers 12/13/14.
  - Status/Cause bit positions.
  - ExcCode values.
  - FSM state encoding.
- One sub-module is natural: cp0_regfile (Status/Cause/EPC storage, field masks, rdata mux). The FSM and priority logic stay in cp0_exc_ctrl.

Test Plan:
- Reset then read: rst_n=0 for 2 cycles, rd_addr=12/13/14 → rdata=0 each; redirect_valid=0.
- mtc0 Status: op=010, rd=12, wdata=32'hFFFF_FFFF → next cycle rdata(12)=32'h0000_FC03; read in the same cycle returns 0.
- syscall: wb_pc=32'h0000_0040, ready=1 → next cycle redirect_valid=1, redirect_pc=32'h180, EPC=32'h40, Cause[6:2]=8, Status.EXL=1; IDLE one cycle later.
- Interrupt vs mtc0: Status=32'h0000_0401, irq[0]=1 (synced), commit mtc0 rd=14 wdata=32'hDEAD_BEEF at pc=32'h100 → EPC=32'h100 (not DEADBEEF), ExcCode=0, redirect_pc=32'h180.
- ERET with backpressure: EXL=1, EPC=32'h200, ready=0 for 3 cycles → redirect_valid held 3 cycles with pc 32'h200; a syscall in that window is ignored; ready=1 → IDLE; EXL=0.
- Reset mid-REDIRECT: rst_n=0 during REDIRECT → next cycle redirect_valid=0, state IDLE, EPC=0.
